// File: rtl/mac_row_engine_pkg.sv
// Shared state encoding and sizing helpers for the row dot-product engine.
package mac_row_engine_pkg;

    typedef logic [1:0] mac_state_t;

    localparam mac_state_t IDLE  = 2'd0;
    localparam mac_state_t SETUP = 2'd1;
    localparam mac_state_t MAC   = 2'd2;
    localparam mac_state_t HOLD  = 2'd3;

    // Accumulator width: full product plus enough headroom for a whole row plus a sign bit.
    function automatic int acc_width(input int pix_w, input int wgt_w, input int row_len);
        return pix_w + wgt_w + $clog2(row_len) + 1;
    endfunction

    // Number of RAM words (beats) that make up one row.
    function automatic int beat_count(input int row_len, input int lanes);
        return row_len / lanes;
    endfunction

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int count_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mac_row_engine_lane_sum.sv
// Combinational multiply-add across all lanes of one RAM beat.
// Operands are sign- or zero-extended by one bit so a single signed multiplier
// serves both modes; each product is then widened to the accumulator width.
module mac_row_engine_lane_sum #(
    parameter int LANES = 2,
    parameter int PIX_W = 8,
    parameter int WGT_W = 16,
    parameter int ACC_W = 34
) (
    input  logic                     signed_mode,
    input  logic [LANES*PIX_W-1:0]   pix_word,
    input  logic [LANES*WGT_W-1:0]   wgt_word,
    output logic [ACC_W-1:0]         lane_sum
);

    localparam int PROD_W = PIX_W + WGT_W + 2;

    logic [ACC_W-1:0] lane_prod [LANES];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [PIX_W:0]            pix_ext;
        logic [WGT_W:0]            wgt_ext;
        logic signed [PROD_W-1:0]  prod;

        assign pix_ext = {signed_mode & pix_word[k*PIX_W + PIX_W - 1], pix_word[k*PIX_W +: PIX_W]};
        assign wgt_ext = {signed_mode & wgt_word[k*WGT_W + WGT_W - 1], wgt_word[k*WGT_W +: WGT_W]};
        assign prod    = PROD_W'($signed(pix_ext)) * PROD_W'($signed(wgt_ext));
        assign lane_prod[k] = ACC_W'(prod);
    end

    // Add up the per-lane products of this beat.
    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum = lane_sum + lane_prod[k];
        end
    end

endmodule

// File: rtl/mac_row_engine.sv
// Row dot-product engine: streams one pixel row and one weight row from
// synchronous RAMs, accumulates LANES products per beat and hands the
// saturated or wrapped result to the writer over a valid/ready pair.
module mac_row_engine
    import mac_row_engine_pkg::*;
#(
    parameter int LANES    = 2,
    parameter int PIX_W    = 8,
    parameter int WGT_W    = 16,
    parameter int ROW_LEN  = 392,
    parameter int NUM_ROWS = 10,
    parameter int RES_W    = 32,
    parameter int PIX_AW   = 10,
    parameter int PIX_BASE = 0,
    parameter int WGT_AW   = 12,
    parameter int WGT_BASE = 0
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [$clog2(NUM_ROWS)-1:0]   row_select,
    input  logic                          signed_mode,
    input  logic                          saturate,
    input  logic [LANES*PIX_W-1:0]        pix_rdata,
    input  logic [LANES*WGT_W-1:0]        wgt_rdata,
    output logic                          mem_ren,
    output logic [PIX_AW-1:0]             pix_addr,
    output logic [WGT_AW-1:0]             wgt_addr,
    output logic                          busy,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic [RES_W-1:0]              row_result,
    output logic                          overflow
);

    localparam int BEATS = beat_count(ROW_LEN, LANES);
    localparam int ACC_W = acc_width(PIX_W, WGT_W, ROW_LEN);
    localparam int CNT_W = count_width(BEATS);
    localparam int ROW_W = $clog2(NUM_ROWS);
    localparam int EXT_W = ((ACC_W > RES_W) ? ACC_W : RES_W) + 1;

    mac_state_t         state;
    mac_state_t         state_next;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]   issue_beat;
    logic               last_beat;
    logic               handshake;
    logic               accept_start;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   lane_sum;
    logic [ROW_W-1:0]   row_q;
    logic               signed_q;
    logic               saturate_q;
    logic [EXT_W-1:0]   acc_ext;
    logic               ovf_signed;
    logic               ovf_unsigned;
    logic               ovf_comb;
    logic [RES_W-1:0]   res_comb;

    mac_row_engine_lane_sum #(
        .LANES (LANES),
        .PIX_W (PIX_W),
        .WGT_W (WGT_W),
        .ACC_W (ACC_W)
    ) u_lane_sum (
        .signed_mode (signed_q),
        .pix_word    (pix_rdata),
        .wgt_word    (wgt_rdata),
        .lane_sum    (lane_sum)
    );

    assign last_beat    = (beat_cnt == CNT_W'(BEATS - 1));
    assign handshake    = result_valid && result_ready;
    assign accept_start = start && !abort && ((state == IDLE) || (state == HOLD && handshake));
    assign busy         = (state != IDLE);

    // Next-state decision; abort overrides everything, HOLD can chain straight into a new row.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETUP;
            SETUP:   state_next = MAC;
            MAC:     if (last_beat) state_next = HOLD;
            HOLD:    if (handshake) state_next = start ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    // Beat counter: tracks which data beat is arriving during MAC, restarts at zero otherwise.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                                     beat_cnt <= '0;
        else if (abort || state != MAC || last_beat)    beat_cnt <= '0;
        else                                            beat_cnt <= beat_cnt + CNT_W'(1);
    end

    // Capture the row and arithmetic mode when a request is accepted so they stay fixed for the row.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            row_q      <= '0;
            signed_q   <= 1'b0;
            saturate_q <= 1'b0;
        end else if (accept_start) begin
            row_q      <= (32'(row_select) < NUM_ROWS) ? row_select : '0;
            signed_q   <= signed_mode;
            saturate_q <= saturate;
        end
    end

    // Accumulator: cleared in SETUP or on abort, adds one beat of lane products per MAC cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                          acc <= '0;
        else if (abort || state == SETUP)    acc <= '0;
        else if (state == MAC)               acc <= acc + lane_sum;
    end

    // Range check and clamp of the finished sum against the result width.
    always_comb begin
        acc_ext      = {{(EXT_W-ACC_W){acc[ACC_W-1]}}, acc};
        ovf_signed   = !((&acc_ext[EXT_W-1:RES_W-1]) || !(|acc_ext[EXT_W-1:RES_W-1]));
        ovf_unsigned = |acc_ext[EXT_W-1:RES_W];
        ovf_comb     = signed_q ? ovf_signed : ovf_unsigned;
        res_comb     = acc_ext[RES_W-1:0];
        if (saturate_q && ovf_comb) begin
            if (signed_q) res_comb = acc_ext[EXT_W-1] ? {1'b1, {(RES_W-1){1'b0}}} : {1'b0, {(RES_W-1){1'b1}}};
            else          res_comb = acc_ext[EXT_W-1] ? '0 : '1;
        end
    end

    // Result registers: loaded on the first HOLD cycle, held until the writer takes them.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            result_valid <= 1'b0;
            row_result   <= '0;
            overflow     <= 1'b0;
        end else if (abort) begin
            result_valid <= 1'b0;
        end else if (state == HOLD && !result_valid) begin
            result_valid <= 1'b1;
            row_result   <= res_comb;
            overflow     <= ovf_comb;
        end else if (handshake) begin
            result_valid <= 1'b0;
        end
    end

    // RAM read strobe and addresses; SETUP issues beat 0, each MAC cycle issues the following beat.
    always_comb begin
        mem_ren    = (state == SETUP) || (state == MAC && !last_beat);
        issue_beat = (state == MAC) ? beat_cnt + CNT_W'(1) : '0;
        pix_addr   = PIX_AW'(PIX_BASE);
        wgt_addr   = WGT_AW'(WGT_BASE);
        if (mem_ren) begin
            pix_addr = PIX_AW'(PIX_BASE) + PIX_AW'(issue_beat);
            wgt_addr = WGT_AW'(WGT_BASE) + WGT_AW'(row_q) * WGT_AW'(BEATS) + WGT_AW'(issue_beat);
        end
    end

endmodule

// File: tb/tb_mac_row_engine.sv
// Directed bench for mac_row_engine: a short-row 16-bit-result instance and a
// default-parameter instance, each fed by a small synchronous RAM model.
module tb_mac_row_engine;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Short-row instance: ROW_LEN=4 (2 beats), RES_W=16
    logic        s_start = 0, s_abort = 0, s_signed = 0, s_sat = 0, s_ready = 0;
    logic [3:0]  s_row = 0;
    logic [15:0] s_pix_rdata = 0;
    logic [31:0] s_wgt_rdata = 0;
    logic        s_mem_ren, s_busy, s_valid, s_ovf;
    logic [9:0]  s_pix_addr;
    logic [11:0] s_wgt_addr;
    logic [15:0] s_result;

    // Default instance: ROW_LEN=392 (196 beats), RES_W=32
    logic        d_start = 0, d_abort = 0, d_signed = 0, d_sat = 0, d_ready = 0;
    logic [3:0]  d_row = 0;
    logic [15:0] d_pix_rdata = 0;
    logic [31:0] d_wgt_rdata = 0;
    logic        d_mem_ren, d_busy, d_valid, d_ovf;
    logic [9:0]  d_pix_addr;
    logic [11:0] d_wgt_addr;
    logic [31:0] d_result;

    logic [7:0]  pix_fill_s = 0, pix_fill_d = 0;
    logic [15:0] wgt_fill_s = 0, wgt_fill_d = 0;
    logic        ramp_s = 0;
    logic        mon_clear = 0;

    int s_ren_cnt = 0, s_wgt_first = 0, s_wgt_last = 0;
    int d_ren_cnt = 0, d_wgt_first = 0, d_wgt_last = 0, d_pix_first = 0, d_pix_last = 0, d_gap_err = 0;

    mac_row_engine #(
        .LANES(2), .PIX_W(8), .WGT_W(16), .ROW_LEN(4), .NUM_ROWS(10), .RES_W(16),
        .PIX_AW(10), .PIX_BASE(0), .WGT_AW(12), .WGT_BASE(0)
    ) dut_s (
        .clk(clk), .n_rst(n_rst), .start(s_start), .abort(s_abort), .row_select(s_row),
        .signed_mode(s_signed), .saturate(s_sat), .pix_rdata(s_pix_rdata), .wgt_rdata(s_wgt_rdata),
        .mem_ren(s_mem_ren), .pix_addr(s_pix_addr), .wgt_addr(s_wgt_addr), .busy(s_busy),
        .result_valid(s_valid), .result_ready(s_ready), .row_result(s_result), .overflow(s_ovf)
    );

    mac_row_engine dut_d (
        .clk(clk), .n_rst(n_rst), .start(d_start), .abort(d_abort), .row_select(d_row),
        .signed_mode(d_signed), .saturate(d_sat), .pix_rdata(d_pix_rdata), .wgt_rdata(d_wgt_rdata),
        .mem_ren(d_mem_ren), .pix_addr(d_pix_addr), .wgt_addr(d_wgt_addr), .busy(d_busy),
        .result_valid(d_valid), .result_ready(d_ready), .row_result(d_result), .overflow(d_ovf)
    );

    // RAM models: one-cycle read latency; the ramp pattern makes pixel element n equal n+1
    // and every weight lane equal its own word address.
    always @(posedge clk) begin
        if (s_mem_ren) begin
            s_pix_rdata <= ramp_s ? {8'(2*s_pix_addr + 2), 8'(2*s_pix_addr + 1)} : {2{pix_fill_s}};
            s_wgt_rdata <= ramp_s ? {2{16'(s_wgt_addr)}} : {2{wgt_fill_s}};
        end
        if (d_mem_ren) begin
            d_pix_rdata <= {2{pix_fill_d}};
            d_wgt_rdata <= {2{wgt_fill_d}};
        end
    end

    // Address monitors: count read strobes and remember first/last addresses.
    always @(negedge clk) begin
        if (mon_clear) begin
            s_ren_cnt <= 0; d_ren_cnt <= 0; d_gap_err <= 0;
        end else begin
            if (s_mem_ren) begin
                if (s_ren_cnt == 0) s_wgt_first <= int'(s_wgt_addr);
                s_wgt_last <= int'(s_wgt_addr);
                s_ren_cnt  <= s_ren_cnt + 1;
            end
            if (d_mem_ren) begin
                if (d_ren_cnt == 0) begin
                    d_wgt_first <= int'(d_wgt_addr);
                    d_pix_first <= int'(d_pix_addr);
                end else if (int'(d_wgt_addr) != d_wgt_last + 1 || int'(d_pix_addr) != d_pix_last + 1) begin
                    d_gap_err <= d_gap_err + 1;
                end
                d_wgt_last <= int'(d_wgt_addr);
                d_pix_last <= int'(d_pix_addr);
                d_ren_cnt  <= d_ren_cnt + 1;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon;
        mon_clear = 1'b1;
        @(negedge clk);
        #1 mon_clear = 1'b0;
    endtask

    // Start a row on the short instance; lat returns the cycle index where result_valid is first seen.
    task automatic run_s(output int lat);
        s_start = 1'b1;
        tick;
        s_start = 1'b0;
        lat = 0;
        while (s_valid !== 1'b1 && lat < 40) begin tick; lat++; end
    endtask

    task automatic run_d(output int lat);
        d_start = 1'b1;
        tick;
        d_start = 1'b0;
        lat = 0;
        while (d_valid !== 1'b1 && lat < 400) begin tick; lat++; end
    endtask

    task automatic take_s;
        s_ready = 1'b1; tick; s_ready = 1'b0;
    endtask

    task automatic take_d;
        d_ready = 1'b1; tick; d_ready = 1'b0;
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        #3;
        tests_run++; if (s_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_s_busy: got %b expected 0", s_busy); end
        tests_run++; if (s_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_s_valid: got %b expected 0", s_valid); end
        tests_run++; if (s_mem_ren !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_s_ren: got %b expected 0", s_mem_ren); end
        tests_run++; if (d_result !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_d_result: got %h expected 0", d_result); end
        tests_run++; if (d_ovf !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_d_ovf: got %b expected 0", d_ovf); end
        tests_run++; if (d_pix_addr !== 10'd0 || d_wgt_addr !== 12'd0) begin tests_failed++; $display("[TB] FAIL reset_d_addr: got %0d/%0d expected 0/0", d_pix_addr, d_wgt_addr); end
        tick; tick;
        n_rst = 1'b1;
        tick;
        tests_run++; if (d_busy !== 1'b0 || s_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_idle: got %b%b expected 00", s_busy, d_busy); end
    endtask

    task automatic test_unsigned_basic;
        int lat;
        ramp_s = 0; pix_fill_s = 8'h02; wgt_fill_s = 16'h0003; s_signed = 0; s_sat = 0; s_row = 0;
        clear_mon;
        run_s(lat);
        tests_run++; if (lat != 4) begin tests_failed++; $display("[TB] FAIL basic_latency: got %0d expected 4", lat); end
        tests_run++; if (s_result !== 16'd24) begin tests_failed++; $display("[TB] FAIL basic_result: got %0d expected 24", s_result); end
        tests_run++; if (s_ovf !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_ovf: got %b expected 0", s_ovf); end
        tests_run++; if (s_ren_cnt != 2) begin tests_failed++; $display("[TB] FAIL basic_ren_count: got %0d expected 2", s_ren_cnt); end
        tests_run++; if (s_wgt_first != 0 || s_wgt_last != 1) begin tests_failed++; $display("[TB] FAIL basic_wgt_addr: got %0d..%0d expected 0..1", s_wgt_first, s_wgt_last); end
        take_s;
        tests_run++; if (s_valid !== 1'b0 || s_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_release: got valid %b busy %b expected 0 0", s_valid, s_busy); end
    endtask

    task automatic test_row_ramp;
        int lat;
        ramp_s = 1; s_signed = 0; s_sat = 0; s_row = 4'd2;
        clear_mon;
        s_start = 1'b1; tick; s_start = 1'b0;
        tick; tick;
        s_row = 4'd0; s_start = 1'b1; tick; s_start = 1'b0;
        lat = 3;
        while (s_valid !== 1'b1 && lat < 40) begin tick; lat++; end
        tests_run++; if (lat != 4) begin tests_failed++; $display("[TB] FAIL ramp_latency: got %0d expected 4", lat); end
        tests_run++; if (s_result !== 16'd47) begin tests_failed++; $display("[TB] FAIL ramp_row2_result: got %0d expected 47", s_result); end
        tests_run++; if (s_wgt_first != 4 || s_wgt_last != 5) begin tests_failed++; $display("[TB] FAIL ramp_row2_addr: got %0d..%0d expected 4..5", s_wgt_first, s_wgt_last); end
        take_s;
        s_row = 4'd12;
        clear_mon;
        run_s(lat);
        tests_run++; if (s_result !== 16'd7) begin tests_failed++; $display("[TB] FAIL ramp_badrow_result: got %0d expected 7", s_result); end
        tests_run++; if (s_wgt_first != 0) begin tests_failed++; $display("[TB] FAIL ramp_badrow_addr: got %0d expected 0", s_wgt_first); end
        take_s;
        ramp_s = 0;
    endtask

    task automatic test_saturation;
        int lat;
        pix_fill_s = 8'hFF; wgt_fill_s = 16'hFFFF; s_signed = 0; s_row = 0;
        s_sat = 1; run_s(lat);
        tests_run++; if ({s_ovf, s_result} !== {1'b1, 16'hFFFF}) begin tests_failed++; $display("[TB] FAIL sat_unsigned_clamp: got %b/%h expected 1/ffff", s_ovf, s_result); end
        take_s;
        s_sat = 0; run_s(lat);
        tests_run++; if ({s_ovf, s_result} !== {1'b1, 16'hFC04}) begin tests_failed++; $display("[TB] FAIL sat_unsigned_wrap: got %b/%h expected 1/fc04", s_ovf, s_result); end
        take_s;
        pix_fill_s = 8'h80; wgt_fill_s = 16'h7FFF; s_signed = 1;
        s_sat = 1; run_s(lat);
        tests_run++; if ({s_ovf, s_result} !== {1'b1, 16'h8000}) begin tests_failed++; $display("[TB] FAIL sat_signed_clamp: got %b/%h expected 1/8000", s_ovf, s_result); end
        take_s;
        s_sat = 0; run_s(lat);
        tests_run++; if ({s_ovf, s_result} !== {1'b1, 16'h0200}) begin tests_failed++; $display("[TB] FAIL sat_signed_wrap: got %b/%h expected 1/0200", s_ovf, s_result); end
        take_s;
        pix_fill_s = 8'hFF; wgt_fill_s = 16'h0005; s_sat = 1; run_s(lat);
        tests_run++; if ({s_ovf, s_result} !== {1'b0, 16'hFFEC}) begin tests_failed++; $display("[TB] FAIL sat_signed_inrange: got %b/%h expected 0/ffec", s_ovf, s_result); end
        take_s;
        s_signed = 0; s_sat = 0;
    endtask

    task automatic test_signed_default;
        int lat;
        pix_fill_d = 8'hFF; wgt_fill_d = 16'h0005; d_signed = 1; d_sat = 1; d_row = 0;
        run_d(lat);
        tests_run++; if (lat != 198) begin tests_failed++; $display("[TB] FAIL signed_latency: got %0d expected 198", lat); end
        tests_run++; if (d_result !== 32'hFFFF_F858) begin tests_failed++; $display("[TB] FAIL signed_result: got %h expected fffff858", d_result); end
        tests_run++; if (d_ovf !== 1'b0) begin tests_failed++; $display("[TB] FAIL signed_ovf: got %b expected 0", d_ovf); end
        take_d;
    endtask

    task automatic test_row_sweep;
        int lat;
        pix_fill_d = 8'h01; wgt_fill_d = 16'h0001; d_signed = 0; d_sat = 0; d_row = 4'd3;
        clear_mon;
        run_d(lat);
        tests_run++; if (d_result !== 32'd392) begin tests_failed++; $display("[TB] FAIL sweep_result: got %0d expected 392", d_result); end
        tests_run++; if (d_ren_cnt != 196) begin tests_failed++; $display("[TB] FAIL sweep_ren_count: got %0d expected 196", d_ren_cnt); end
        tests_run++; if (d_wgt_first != 588 || d_wgt_last != 783) begin tests_failed++; $display("[TB] FAIL sweep_wgt_addr: got %0d..%0d expected 588..783", d_wgt_first, d_wgt_last); end
        tests_run++; if (d_pix_first != 0 || d_pix_last != 195) begin tests_failed++; $display("[TB] FAIL sweep_pix_addr: got %0d..%0d expected 0..195", d_pix_first, d_pix_last); end
        tests_run++; if (d_gap_err != 0) begin tests_failed++; $display("[TB] FAIL sweep_contiguous: got %0d gaps expected 0", d_gap_err); end
        take_d;
    endtask

    task automatic test_back_to_back;
        int lat;
        logic busy_dropped;
        ramp_s = 0; pix_fill_s = 8'h02; wgt_fill_s = 16'h0003; s_signed = 0; s_sat = 0; s_row = 0;
        run_s(lat);
        tests_run++; if (lat != 4) begin tests_failed++; $display("[TB] FAIL b2b_first_latency: got %0d expected 4", lat); end
        for (int i = 0; i < 10; i++) begin
            tick;
            tests_run++; if ({s_valid, s_result} !== {1'b1, 16'd24}) begin tests_failed++; $display("[TB] FAIL b2b_hold_%0d: got %b/%0d expected 1/24", i, s_valid, s_result); end
        end
        pix_fill_s = 8'h01; wgt_fill_s = 16'h0007;
        s_ready = 1'b1; s_start = 1'b1; tick; s_ready = 1'b0; s_start = 1'b0;
        tests_run++; if ({s_busy, s_mem_ren, s_valid} !== 3'b110) begin tests_failed++; $display("[TB] FAIL b2b_setup: got busy/ren/valid %b%b%b expected 110", s_busy, s_mem_ren, s_valid); end
        lat = 0; busy_dropped = 1'b0;
        while (s_valid !== 1'b1 && lat < 40) begin
            tick; lat++;
            if (s_busy !== 1'b1) busy_dropped = 1'b1;
        end
        tests_run++; if (lat != 4 || busy_dropped !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_second_run: got latency %0d busy_drop %b expected 4 0", lat, busy_dropped); end
        tests_run++; if (s_result !== 16'd28) begin tests_failed++; $display("[TB] FAIL b2b_second_result: got %0d expected 28", s_result); end
        take_s;
    endtask

    task automatic test_abort;
        int lat;
        logic seen_valid;
        pix_fill_d = 8'h02; wgt_fill_d = 16'h0003; d_signed = 0; d_sat = 0; d_row = 0;
        d_start = 1'b1; tick; d_start = 1'b0;
        for (int i = 0; i < 51; i++) tick;
        tests_run++; if (d_mem_ren !== 1'b1 || d_pix_addr !== 10'd51) begin tests_failed++; $display("[TB] FAIL abort_pre_addr: got ren %b addr %0d expected 1 51", d_mem_ren, d_pix_addr); end
        d_abort = 1'b1; d_start = 1'b1; tick; d_abort = 1'b0; d_start = 1'b0;
        tests_run++; if ({d_busy, d_mem_ren} !== 2'b00) begin tests_failed++; $display("[TB] FAIL abort_idle: got busy/ren %b%b expected 00", d_busy, d_mem_ren); end
        seen_valid = 1'b0;
        for (int i = 0; i < 210; i++) begin
            tick;
            if (d_valid !== 1'b0) seen_valid = 1'b1;
        end
        tests_run++; if (seen_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_no_result: got %b expected 0", seen_valid); end
        run_d(lat);
        tests_run++; if (lat != 198 || d_result !== 32'd2352) begin tests_failed++; $display("[TB] FAIL abort_rerun: got latency %0d result %0d expected 198 2352", lat, d_result); end
        take_d;
    endtask

    task automatic test_async_reset;
        int lat;
        ramp_s = 1; s_signed = 0; s_sat = 0; s_row = 4'd2;
        s_start = 1'b1; tick; s_start = 1'b0;
        tick;
        #2 n_rst = 1'b0;
        #1;
        tests_run++; if ({s_busy, s_mem_ren, s_valid} !== 3'b000) begin tests_failed++; $display("[TB] FAIL async_reset_outputs: got %b%b%b expected 000", s_busy, s_mem_ren, s_valid); end
        tests_run++; if (s_pix_addr !== 10'd0) begin tests_failed++; $display("[TB] FAIL async_reset_addr: got %0d expected 0", s_pix_addr); end
        tick; tick;
        n_rst = 1'b1;
        tick;
        run_s(lat);
        tests_run++; if (lat != 4 || s_result !== 16'd47) begin tests_failed++; $display("[TB] FAIL async_reset_rerun: got latency %0d result %0d expected 4 47", lat, s_result); end
        take_s;
        ramp_s = 0;
    endtask

    initial begin
        test_reset;
        test_unsigned_basic;
        test_row_ramp;
        test_saturation;
        test_signed_default;
        test_row_sweep;
        test_back_to_back;
        test_abort;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
